// File: rtl/fwd_scoreboard.sv
// Operand forwarding selector, long-latency writeback scoreboard and the
// ID/EXE stall signals derived from them.
module fwd_scoreboard #(
  parameter int REG_BITS   = 5,
  parameter int NUM_SRC    = 2,
  parameter int FWD_STAGES = 2,
  parameter int MAX_PEND   = 4,
  parameter int FWD_BITS   = $clog2(FWD_STAGES + 1)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                id_valid_i,
  input  logic [NUM_SRC*REG_BITS-1:0]         id_rs_addr_i,
  input  logic [NUM_SRC-1:0]                  id_rs_used_i,
  input  logic [REG_BITS-1:0]                 id_rd_addr_i,
  input  logic                                id_long_i,
  input  logic [NUM_SRC*REG_BITS-1:0]         exe_rs_addr_i,
  input  logic [FWD_STAGES-1:0]               stg_reg_wr_i,
  input  logic [FWD_STAGES*REG_BITS-1:0]      stg_rd_addr_i,
  input  logic [FWD_STAGES-1:0]               stg_ready_i,
  input  logic                                lc_valid_i,
  input  logic [REG_BITS-1:0]                 lc_addr_i,
  output logic [NUM_SRC*FWD_BITS-1:0]         forward_sel_o,
  output logic                                exe_stall_o,
  output logic                                id_stall_o,
  output logic [$clog2(MAX_PEND+1)-1:0]       pend_cnt_o,
  output logic [15:0]                         stall_cycles_o,
  output logic                                proto_err_o
);

  localparam int NREG = 1 << REG_BITS;
  localparam int CW   = $clog2(MAX_PEND + 1);

  logic [NREG-1:0] pend_q, pend_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [15:0]     stall_q, stall_d;
  logic            err_q, err_d;

  logic            lc_clr;
  logic            lc_bad;
  logic            sb_set;

  // Nearest writing stage wins; its readiness alone decides the EXE stall.
  always_comb begin
    logic [REG_BITS-1:0] src;
    logic                found;
    forward_sel_o = '0;
    exe_stall_o   = 1'b0;
    src           = '0;
    found         = 1'b0;
    for (int unsigned j = 0; j < NUM_SRC; j++) begin
      src   = exe_rs_addr_i[j*REG_BITS +: REG_BITS];
      found = 1'b0;
      if (src != '0) begin
        for (int unsigned k = 0; k < FWD_STAGES; k++) begin
          if (!found && stg_reg_wr_i[k] &&
              stg_rd_addr_i[k*REG_BITS +: REG_BITS] == src) begin
            found = 1'b1;
            forward_sel_o[j*FWD_BITS +: FWD_BITS] = FWD_BITS'(k + 1);
            if (!stg_ready_i[k]) begin
              exe_stall_o = 1'b1;
            end
          end
        end
      end
    end
  end

  // A completion on the same register this cycle is written through.
  always_comb begin
    logic [REG_BITS-1:0] a;
    id_stall_o = 1'b0;
    a          = '0;
    for (int unsigned j = 0; j < NUM_SRC; j++) begin
      a = id_rs_addr_i[j*REG_BITS +: REG_BITS];
      if (id_rs_used_i[j] && a != '0 && pend_q[a] &&
          !(lc_valid_i && lc_addr_i == a)) begin
        id_stall_o = 1'b1;
      end
    end
    if (id_long_i && id_rd_addr_i != '0) begin
      if (pend_q[id_rd_addr_i] &&
          !(lc_valid_i && lc_addr_i == id_rd_addr_i)) begin
        id_stall_o = 1'b1;
      end
      if (cnt_q == CW'(MAX_PEND) && !lc_valid_i) begin
        id_stall_o = 1'b1;
      end
    end
  end

  always_comb begin
    lc_clr = lc_valid_i && lc_addr_i != '0 && pend_q[lc_addr_i];
    lc_bad = lc_valid_i && !lc_clr;
    sb_set = id_valid_i && !id_stall_o && id_long_i && id_rd_addr_i != '0;

    pend_d = pend_q;
    if (lc_clr) begin
      pend_d[lc_addr_i] = 1'b0;
    end
    if (sb_set) begin
      pend_d[id_rd_addr_i] = 1'b1;
    end
    pend_d[0] = 1'b0;

    cnt_d = cnt_q + CW'(sb_set) - CW'(lc_clr);
    err_d = err_q | lc_bad;

    stall_d = stall_q;
    if ((id_stall_o || exe_stall_o) && stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q  <= '0;
      cnt_q   <= '0;
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  assign pend_cnt_o     = cnt_q;
  assign stall_cycles_o = stall_q;
  assign proto_err_o    = err_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Bench for fwd_scoreboard: forwarding vector table, hand-written scoreboard
// sequences, then random traffic against a set-based reference model.
module tb_fwd_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid_i;
  logic [9:0]  id_rs_addr_i;
  logic [1:0]  id_rs_used_i;
  logic [4:0]  id_rd_addr_i;
  logic        id_long_i;
  logic [9:0]  exe_rs_addr_i;
  logic [1:0]  stg_reg_wr_i;
  logic [9:0]  stg_rd_addr_i;
  logic [1:0]  stg_ready_i;
  logic        lc_valid_i;
  logic [4:0]  lc_addr_i;
  logic [3:0]  forward_sel_o;
  logic        exe_stall_o;
  logic        id_stall_o;
  logic [2:0]  pend_cnt_o;
  logic [15:0] stall_cycles_o;
  logic        proto_err_o;

  fwd_scoreboard #(
    .REG_BITS(5), .NUM_SRC(2), .FWD_STAGES(2), .MAX_PEND(4)
  ) dut (
    .clk(clk), .rst(rst),
    .id_valid_i(id_valid_i), .id_rs_addr_i(id_rs_addr_i),
    .id_rs_used_i(id_rs_used_i), .id_rd_addr_i(id_rd_addr_i),
    .id_long_i(id_long_i), .exe_rs_addr_i(exe_rs_addr_i),
    .stg_reg_wr_i(stg_reg_wr_i), .stg_rd_addr_i(stg_rd_addr_i),
    .stg_ready_i(stg_ready_i), .lc_valid_i(lc_valid_i), .lc_addr_i(lc_addr_i),
    .forward_sel_o(forward_sel_o), .exe_stall_o(exe_stall_o),
    .id_stall_o(id_stall_o), .pend_cnt_o(pend_cnt_o),
    .stall_cycles_o(stall_cycles_o), .proto_err_o(proto_err_o)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] m_pend;
  int          m_stall;
  logic        m_err;

  typedef struct {
    logic [9:0] exe_rs;
    logic [1:0] wr;
    logic [9:0] rd;
    logic [1:0] rdy;
    logic [3:0] sel;
    logic       xs;
  } fvec_t;
  fvec_t tv[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    id_valid_i = 0; id_rs_addr_i = '0; id_rs_used_i = '0; id_rd_addr_i = '0;
    id_long_i = 0; exe_rs_addr_i = '0; stg_reg_wr_i = '0; stg_rd_addr_i = '0;
    stg_ready_i = 2'b11; lc_valid_i = 0; lc_addr_i = '0;
  endtask

  task automatic model_reset();
    m_pend = '0; m_stall = 0; m_err = 0;
  endtask

  task automatic model_comb(output logic [3:0] sel, output logic xs, output logic is);
    logic [4:0] a;
    int         s;
    logic       r;
    sel = '0; xs = 0; is = 0;
    for (int j = 0; j < 2; j++) begin
      a = exe_rs_addr_i[j*5 +: 5]; s = 0; r = 1;
      if (a != 0)
        for (int k = 1; k >= 0; k--)
          if (stg_reg_wr_i[k] && stg_rd_addr_i[k*5 +: 5] == a) begin
            s = k + 1; r = stg_ready_i[k];
          end
      sel[j*2 +: 2] = 2'(s);
      if (s != 0 && !r) xs = 1;
      a = id_rs_addr_i[j*5 +: 5];
      if (id_rs_used_i[j] && a != 0 && m_pend[a] && !(lc_valid_i && lc_addr_i == a)) is = 1;
    end
    if (id_long_i && id_rd_addr_i != 0) begin
      if (m_pend[id_rd_addr_i] && !(lc_valid_i && lc_addr_i == id_rd_addr_i)) is = 1;
      if ($countones(m_pend) == 4 && !lc_valid_i) is = 1;
    end
  endtask

  task automatic model_update(input logic xs, input logic is);
    logic [31:0] nxt;
    nxt = m_pend;
    if (lc_valid_i) begin
      if (lc_addr_i != 0 && m_pend[lc_addr_i]) nxt[lc_addr_i] = 0;
      else m_err = 1;
    end
    if (id_valid_i && !is && id_long_i && id_rd_addr_i != 0) nxt[id_rd_addr_i] = 1;
    m_pend = nxt;
    if ((is || xs) && m_stall < 65535) m_stall++;
  endtask

  // Called at a negedge with inputs applied; returns at the following negedge.
  task automatic step();
    logic [3:0] es;
    logic       ex, ei;
    model_comb(es, ex, ei);
    #1;
    check("forward_sel", 32'(forward_sel_o), 32'(es));
    check("exe_stall", 32'(exe_stall_o), 32'(ex));
    check("id_stall", 32'(id_stall_o), 32'(ei));
    model_update(ex, ei);
    @(posedge clk); #1;
    check("pend_cnt", 32'(pend_cnt_o), 32'($countones(m_pend)));
    check("stall_cycles", 32'(stall_cycles_o), 32'(m_stall));
    check("proto_err", 32'(proto_err_o), 32'(m_err));
    @(negedge clk);
  endtask

  task automatic mid_reset(input string tag);
    rst = 1; #1;
    check({tag, " pend_cnt"}, 32'(pend_cnt_o), 0);
    check({tag, " stall_cycles"}, 32'(stall_cycles_o), 0);
    check({tag, " proto_err"}, 32'(proto_err_o), 0);
    model_reset();
    idle(); #1;
    check({tag, " forward_sel"}, 32'(forward_sel_o), 0);
    check({tag, " id_stall"}, 32'(id_stall_o), 0);
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    tv[0] = '{10'({5'd0, 5'd5}), 2'b11, 10'({5'd5, 5'd5}), 2'b11, 4'b0001, 1'b0};
    tv[1] = '{10'({5'd0, 5'd5}), 2'b10, 10'({5'd5, 5'd5}), 2'b11, 4'b0010, 1'b0};
    tv[2] = '{10'({5'd0, 5'd0}), 2'b11, 10'({5'd0, 5'd0}), 2'b00, 4'b0000, 1'b0};
    tv[3] = '{10'({5'd7, 5'd0}), 2'b11, 10'({5'd7, 5'd7}), 2'b10, 4'b0100, 1'b1};
    tv[4] = '{10'({5'd7, 5'd0}), 2'b11, 10'({5'd7, 5'd7}), 2'b11, 4'b0100, 1'b0};
    tv[5] = '{10'({5'd4, 5'd3}), 2'b11, 10'({5'd3, 5'd4}), 2'b01, 4'b0110, 1'b1};
    tv[6] = '{10'({5'd10, 5'd9}), 2'b11, 10'({5'd2, 5'd1}), 2'b11, 4'b0000, 1'b0};
    tv[7] = '{10'({5'd0, 5'd9}), 2'b00, 10'({5'd9, 5'd9}), 2'b00, 4'b0000, 1'b0};
    tv[8] = '{10'({5'd5, 5'd5}), 2'b01, 10'({5'd5, 5'd5}), 2'b00, 4'b0101, 1'b1};

    idle();
    model_reset();
    rst = 1;
    #12;
    check("reset pend_cnt", 32'(pend_cnt_o), 0);
    check("reset stall_cycles", 32'(stall_cycles_o), 0);
    check("reset proto_err", 32'(proto_err_o), 0);
    check("reset forward_sel", 32'(forward_sel_o), 0);
    check("reset id_stall", 32'(id_stall_o), 0);
    check("reset exe_stall", 32'(exe_stall_o), 0);
    @(negedge clk);
    rst = 0;

    for (int i = 0; i < 9; i++) begin
      idle();
      exe_rs_addr_i = tv[i].exe_rs; stg_reg_wr_i = tv[i].wr;
      stg_rd_addr_i = tv[i].rd;     stg_ready_i  = tv[i].rdy;
      #1;
      check($sformatf("vec%0d sel", i), 32'(forward_sel_o), 32'(tv[i].sel));
      check($sformatf("vec%0d exe_stall", i), 32'(exe_stall_o), 32'(tv[i].xs));
      step();
    end

    // long op to x3, dependent read, write-through completion
    idle(); id_valid_i = 1; id_long_i = 1; id_rd_addr_i = 5'd3;
    step();
    idle(); id_valid_i = 1; id_rs_addr_i = 10'({5'd0, 5'd3}); id_rs_used_i = 2'b01;
    #1;
    check("raw id_stall", 32'(id_stall_o), 1);
    check("raw pend_cnt", 32'(pend_cnt_o), 1);
    step();
    lc_valid_i = 1; lc_addr_i = 5'd3;
    #1;
    check("bypass id_stall", 32'(id_stall_o), 0);
    step();
    check("clear pend_cnt", 32'(pend_cnt_o), 0);

    // fill to MAX_PEND, fifth stalls, same-cycle completion lets it issue
    for (int r = 1; r <= 4; r++) begin
      idle(); id_valid_i = 1; id_long_i = 1; id_rd_addr_i = 5'(r);
      step();
    end
    check("full pend_cnt", 32'(pend_cnt_o), 4);
    idle(); id_valid_i = 1; id_long_i = 1; id_rd_addr_i = 5'd5;
    #1;
    check("full id_stall", 32'(id_stall_o), 1);
    step();
    lc_valid_i = 1; lc_addr_i = 5'd2;
    #1;
    check("full+lc id_stall", 32'(id_stall_o), 0);
    step();
    check("swap pend_cnt", 32'(pend_cnt_o), 4);

    // completion on a non-pending register
    idle(); lc_valid_i = 1; lc_addr_i = 5'd9;
    step();
    check("bogus lc proto_err", 32'(proto_err_o), 1);
    check("bogus lc pend_cnt", 32'(pend_cnt_o), 4);
    mid_reset("midrst");

    for (int c = 0; c < 400; c++) begin
      if (c == 200) mid_reset("rndrst");
      id_valid_i    = 1'($urandom_range(0, 1));
      id_rs_addr_i  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      id_rs_used_i  = 2'($urandom_range(0, 3));
      id_rd_addr_i  = 5'($urandom_range(0, 7));
      id_long_i     = ($urandom_range(0, 2) == 0);
      exe_rs_addr_i = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      stg_reg_wr_i  = 2'($urandom_range(0, 3));
      stg_rd_addr_i = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      stg_ready_i   = 2'($urandom_range(0, 3));
      lc_valid_i    = ($urandom_range(0, 2) == 0);
      lc_addr_i     = 5'($urandom_range(0, 7));
      // keep spurious completions away from a full scoreboard
      if (lc_valid_i && !(lc_addr_i != 0 && m_pend[lc_addr_i]) && $countones(m_pend) >= 4)
        lc_valid_i = 0;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

Parametrised operand-forwarding and interlock unit for the CPU pipeline. It generalises the fixed two-stage, two-source MEM/WB forwarding selector to any number of source operands and forwarding stages. It adds a registered scoreboard for long-latency writebacks (loads over the bus, multi-cycle MUL/DIV) and produces the ID-stage issue stall and the EXE-stage forward-not-ready stall. It sits between the ID/EXE pipeline registers and the hazard/stall controller.

## Interface
- `REG_BITS`, 5: register address width; register 0 is hardwired zero.
- `NUM_SRC`, 2: source operands per instruction.
- `FWD_STAGES`, 2: forwarding stages after EXE; stage 0 is closest (MEM), stage 1 next (WB), and so on.
- `MAX_PEND`, 4: maximum outstanding long-latency writes, 1..2^REG_BITS-1.
- `FWD_BITS`, $clog2(FWD_STAGES+1): width of each forward select.
- `clk` in 1: clock; everything is sampled on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `id_valid_i` in 1: instruction present in ID.
- `id_rs_addr_i` in NUM_SRC*REG_BITS: ID source addresses; source j occupies bits [j*REG_BITS +: REG_BITS].
- `id_rs_used_i` in NUM_SRC: source j is actually read.
- `id_rd_addr_i` in REG_BITS: ID destination.
- `id_long_i` in 1: ID instruction is long-latency and writes rd; it sets the scoreboard when issued.
- `exe_rs_addr_i` in NUM_SRC*REG_BITS: EXE source addresses.
- `stg_reg_wr_i` in FWD_STAGES: stage k writes a register.
- `stg_rd_addr_i` in FWD_STAGES*REG_BITS: stage k destination.
- `stg_ready_i` in FWD_STAGES: stage k result is valid for bypass (low for a load still in MEM).
- `lc_valid_i` in 1: long-latency completion writes the regfile this cycle.
- `lc_addr_i` in REG_BITS: completing register.
- `forward_sel_o` out NUM_SRC*FWD_BITS: per EXE source, 0 = regfile/ID value, k+1 = stage k.
- `exe_stall_o` out 1: EXE must hold because the nearest matching stage is not ready.
- `id_stall_o` out 1: ID must not issue.
- `pend_cnt_o` out $clog2(MAX_PEND+1): outstanding long writes.
- `stall_cycles_o` out 16: saturating count of cycles with id_stall_o or exe_stall_o high.
- `proto_err_o` out 1: sticky protocol error flag.

## Operation
- Forwarding (combinational): for each EXE source j whose address is nonzero, scan k = 0..FWD_STAGES-1. The first stage k with stg_reg_wr_i[k] and stg_rd_addr_i[k] equal to the source address is the match. The select is k+1; with no match it is 0. Address 0 always selects 0.
- exe_stall_o = OR over sources of the condition that the matching stage has stg_ready_i = 0. Only the nearest match counts; a ready older stage never overrides a non-ready nearer one.
- Scoreboard: a 2^REG_BITS pending vector; bit 0 is held at 0.
- issue = id_valid_i & ~id_stall_o.
- id_stall_o is 1 when any of the following holds:
  - a used, nonzero source is pending and is not completing this cycle;
  - id_long_i is set with a nonzero rd that is pending and not completing this cycle (WAW);
  - id_long_i is set with a nonzero rd, pend_cnt_o == MAX_PEND and lc_valid_i is low.
  - A completion on a pending register in the same cycle clears the hazard: the regfile is write-through.
- Update on each edge:
  - lc_valid_i on a pending address clears its bit.
  - An issued long op with nonzero rd sets its bit; set wins when the clear and set target the same address.
  - pend_cnt_o changes by +set −clear, so it is unchanged when both occur.
- lc_valid_i on a non-pending address or on address 0 is ignored for state and sets proto_err_o.
- id_long_i with rd = 0 issues normally and leaves the scoreboard unchanged.
- stall_cycles_o increments while id_stall_o | exe_stall_o and saturates at 0xFFFF.

## Timing
- Forward selects, exe_stall_o and id_stall_o are combinational from the inputs and the current scoreboard; latency is zero cycles.
- A scoreboard set takes effect the cycle after issue. A dependent instruction in ID on the next cycle stalls.
- A clear takes effect in the completion cycle itself, through the bypass term.
- Reset values: pending vector all 0, pend_cnt_o 0, stall_cycles_o 0, proto_err_o 0. After reset, forward_sel_o and the stalls depend only on the stage inputs (all 0 when the inputs are idle).
- rst asserted mid-operation discards all outstanding entries immediately; there are no completions to drain.
- proto_err_o clears only on rst.

## Test plan
- EXE rs1 = 5 with stage 0 and stage 1 both writing x5, both ready -> select for rs1 = 1; with stage 0 not writing -> select = 2; with EXE rs = 0 -> select = 0 regardless.
- Load in stage 0 to x7 with stg_ready_i[0] = 0 and stage 1 writing x7 ready, EXE rs2 = 7 -> exe_stall_o = 1 and select = 1; once stg_ready_i[0] = 1 -> exe_stall_o = 0.
- Issue long op rd = 3, then ID reads x3 -> id_stall_o = 1 and pend_cnt_o = 1. Assert lc_valid_i with addr 3 -> id_stall_o = 0 in that same cycle; pend_cnt_o = 0 next cycle.
- MAX_PEND = 4: issue long ops to x1..x4 -> pend_cnt_o = 4 and a fifth long op stalls. A completion of x2 in the same cycle -> the fifth issues and pend_cnt_o stays at 4.
- Completion on x9 while not pending -> proto_err_o = 1 and the count is unchanged. Assert rst mid-stream -> all outputs return to reset values and proto_err_o = 0.
